// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: character codes, ASCII bytes, output FSM states
// and the code-to-ASCII mapping.
package nw_pkg;

    localparam logic [2:0] CODE_GAP = 3'b000;
    localparam logic [2:0] CODE_G   = 3'b001;
    localparam logic [2:0] CODE_C   = 3'b110;
    localparam logic [2:0] CODE_A   = 3'b100;
    localparam logic [2:0] CODE_T   = 3'b011;

    localparam logic [7:0] ASCII_G     = 8'h47;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_GAP   = 8'h2D;
    localparam logic [7:0] ASCII_UNKN  = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StCr,
        StCrWait,
        StLf,
        StLfWait
    } cod_out_state_e;

    function automatic logic [7:0] map_code(input logic [2:0] code);
        logic [7:0] ch;
        case (code)
            CODE_G:   ch = ASCII_G;
            CODE_C:   ch = ASCII_C;
            CODE_A:   ch = ASCII_A;
            CODE_T:   ch = ASCII_T;
            CODE_GAP: ch = ASCII_GAP;
            default:  ch = ASCII_UNKN;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Parameterised synchronous FIFO with full/empty flags and occupancy count.
// Pushes while full and pops while empty are dropped.
module char_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cod_out.sv
// Output character encoder: buffers traceback codes, maps them to ASCII and paces the UART.
// Define COD_OUT_NEWLINE_EN to append CR/LF after entries flagged with char_last.
module cod_out
    import nw_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   char_in,
    input  logic         char_last,
    input  logic         char_valid,
    output logic         char_ready,
    input  logic         tx_busy,
    input  logic         tx_done,
    output logic [N-1:0] Txdata_in,
    output logic         tx_start,
    output logic         busy
);

`ifdef COD_OUT_NEWLINE_EN
    localparam int unsigned FW = 4;
`else
    localparam int unsigned FW = 3;
`endif

    logic [FW-1:0]          fifo_wdata;
    logic [FW-1:0]          fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;
    cod_out_state_e         state;

`ifdef COD_OUT_NEWLINE_EN
    logic last_q;
    assign fifo_wdata = {char_last, char_in};
`else
    logic unused_last;
    assign unused_last = char_last;
    assign fifo_wdata  = char_in;
`endif

    assign char_ready = ~fifo_full;
    assign fifo_push  = char_valid & char_ready;
    // Dequeue only on the IDLE->START transition.
    assign fifo_pop   = (state == StIdle) & ~fifo_empty & ~tx_busy;
    assign busy       = (fifo_count != '0) | (state != StIdle);

    char_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            Txdata_in <= '0;
            tx_start  <= 1'b0;
`ifdef COD_OUT_NEWLINE_EN
            last_q    <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (fifo_pop) begin
                        Txdata_in <= N'(map_code(fifo_rdata[2:0]));
                        tx_start  <= 1'b1;
`ifdef COD_OUT_NEWLINE_EN
                        last_q    <= fifo_rdata[3];
`endif
                        state     <= StStart;
                    end
                end
                StStart: begin
                    tx_start <= 1'b0;
                    state    <= StWait;
                end
                StWait: begin
                    if (tx_done) begin
`ifdef COD_OUT_NEWLINE_EN
                        if (last_q) begin
                            Txdata_in <= N'(ASCII_CR);
                            tx_start  <= 1'b1;
                            state     <= StCr;
                        end else begin
                            state <= StIdle;
                        end
`else
                        state <= StIdle;
`endif
                    end
                end
`ifdef COD_OUT_NEWLINE_EN
                StCr: begin
                    tx_start <= 1'b0;
                    state    <= StCrWait;
                end
                StCrWait: begin
                    if (tx_done) begin
                        Txdata_in <= N'(ASCII_LF);
                        tx_start  <= 1'b1;
                        state     <= StLf;
                    end
                end
                StLf: begin
                    tx_start <= 1'b0;
                    state    <= StLfWait;
                end
                StLfWait: begin
                    if (tx_done) begin
                        state <= StIdle;
                    end
                end
`endif
                default: begin
                    tx_start <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cod_out.sv
// Directed self-checking bench for cod_out with a simple UART transmitter model.
module tb_cod_out;

    localparam int N     = 8;
    localparam int DEPTH = 8;

    logic         clk;
    logic         rst_n;
    logic [2:0]   char_in;
    logic         char_last;
    logic         char_valid;
    logic         char_ready;
    logic         tx_busy;
    logic         tx_done;
    logic [N-1:0] Txdata_in;
    logic         tx_start;
    logic         busy;

    logic         busy_force;
    logic         spur_done;
    logic         model_busy;
    logic         model_done;
    int           model_cnt;
    int           n_starts     = 0;
    int           overlap_errs = 0;
    logic [7:0]   rx_q [$];

    int           n_checks = 0;
    int           n_fail   = 0;

    logic [2:0] seq_codes [5] = '{3'b110, 3'b100, 3'b011, 3'b000, 3'b101};
    logic [7:0] seq_bytes [5] = '{8'h43, 8'h41, 8'h54, 8'h2D, 8'h3F};
    logic [2:0] fill_codes [10] = '{3'b001, 3'b110, 3'b100, 3'b011, 3'b000,
                                    3'b101, 3'b111, 3'b010, 3'b001, 3'b110};
    logic [7:0] fill_bytes [8] = '{8'h47, 8'h43, 8'h41, 8'h54, 8'h2D, 8'h3F, 8'h3F, 8'h3F};

    assign tx_busy = busy_force | model_busy;
    assign tx_done = model_done | spur_done;

    cod_out #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_last  (char_last),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .Txdata_in  (Txdata_in),
        .tx_start   (tx_start),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: captures the byte on tx_start, pulses tx_done 10 cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_busy <= 1'b0;
            model_done <= 1'b0;
            model_cnt  <= 0;
        end else begin
            model_done <= 1'b0;
            if (tx_start) begin
                if (model_busy) overlap_errs <= overlap_errs + 1;
                rx_q.push_back(Txdata_in[7:0]);
                n_starts   <= n_starts + 1;
                model_busy <= 1'b1;
                model_cnt  <= 10;
            end else if (model_busy) begin
                if (model_cnt == 1) begin
                    model_done <= 1'b1;
                    model_busy <= 1'b0;
                end
                model_cnt <= model_cnt - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic l);
        char_in    = c;
        char_last  = l;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy && !model_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Push 001 in cycle k; expect tx_start and 'G' in cycle k+2, not in k+1.
    task automatic latency_check(input string tag);
        char_in    = 3'b001;
        char_last  = 1'b0;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_k1_start"}, 32'(tx_start), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_k2_start"}, 32'(tx_start), 32'd1);
        chk({tag, "_k2_data"}, 32'(Txdata_in), 32'h47);
    endtask

    initial begin
        int   base;
        int   sbase;
        logic found;

        rst_n      = 1'b0;
        char_in    = 3'b000;
        char_last  = 1'b0;
        char_valid = 1'b0;
        busy_force = 1'b0;
        spur_done  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(char_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(Txdata_in), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_start", 32'(tx_start), 32'd0);

        // Single character latency and busy drop
        base = rx_q.size();
        latency_check("lat");
        chk("lat_busy_high", 32'(busy), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_done) begin
                found = 1'b1;
                break;
            end
        end
        chk("lat_done_seen", 32'(found), 32'd1);
        chk("lat_data_held", 32'(Txdata_in), 32'h47);
        @(negedge clk);
        @(negedge clk);
        chk("lat_busy_drop", 32'(busy), 32'd0);
        chk("lat_rx_count", 32'(rx_q.size() - base), 32'd1);
        chk("lat_rx_byte", 32'(rx_q[base]), 32'h47);
        @(posedge clk);
        #1;

        // Back-to-back codes through the mapping
        base  = rx_q.size();
        sbase = n_starts;
        for (int i = 0; i < 5; i++) push(seq_codes[i], 1'b0);
        wait_idle(500, "seq_idle");
        chk("seq_rx_count", 32'(rx_q.size() - base), 32'd5);
        chk("seq_starts", 32'(n_starts - sbase), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("seq_byte%0d", i), 32'(rx_q[base + i]), 32'(seq_bytes[i]));
        end

        // Fill past DEPTH while the transmitter is busy
        busy_force = 1'b1;
        base  = rx_q.size();
        sbase = n_starts;
        for (int i = 0; i < DEPTH + 2; i++) begin
            char_in    = fill_codes[i];
            char_valid = 1'b1;
            #1;
            chk($sformatf("fill_ready%0d", i), 32'(char_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        char_valid = 1'b0;
        chk("fill_no_start", 32'(n_starts - sbase), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);
        busy_force = 1'b0;
        wait_idle(1000, "fill_idle");
        chk("fill_rx_count", 32'(rx_q.size() - base), 32'(DEPTH));
        chk("fill_starts", 32'(n_starts - sbase), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fill_byte%0d", i), 32'(rx_q[base + i]), 32'(fill_bytes[i]));
        end

        // Last-of-line handling
        base = rx_q.size();
        push(3'b001, 1'b1);
        wait_idle(500, "nl_idle");
`ifdef COD_OUT_NEWLINE_EN
        chk("nl_rx_count", 32'(rx_q.size() - base), 32'd3);
        chk("nl_byte0", 32'(rx_q[base]), 32'h47);
        chk("nl_byte1", 32'(rx_q[base + 1]), 32'h0D);
        chk("nl_byte2", 32'(rx_q[base + 2]), 32'h0A);
`else
        chk("nl_rx_count", 32'(rx_q.size() - base), 32'd1);
        chk("nl_byte0", 32'(rx_q[base]), 32'h47);
`endif

        // Reset while waiting on a frame with 3 entries still buffered
        busy_force = 1'b1;
        push(3'b001, 1'b0);
        push(3'b110, 1'b0);
        push(3'b100, 1'b0);
        push(3'b011, 1'b0);
        busy_force = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstw_start_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        chk("rstw_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_start", 32'(tx_start), 32'd0);
        chk("rstw_data", 32'(Txdata_in), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_ready", 32'(char_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sbase = n_starts;
        repeat (30) @(negedge clk);
        chk("rstw_no_start", 32'(n_starts - sbase), 32'd0);
        chk("rstw_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Spurious tx_done in IDLE
        sbase = n_starts;
        spur_done = 1'b1;
        @(posedge clk);
        #1;
        spur_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("spur_no_start", 32'(n_starts - sbase), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_start_low", 32'(tx_start), 32'd0);
        @(posedge clk);
        #1;
        latency_check("spur_lat");
        @(posedge clk);
        #1;
        wait_idle(100, "spur_idle");

        chk("no_overlap_start", 32'(overlap_errs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
